ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/nessy_mem_pkg.sv | 24 ++
 rtl/ram_stream_reader_if.sv | 29 ++
 rtl/stream_fifo.sv | 48 ++++
 rtl/ram_stream_reader.sv | 149 ++++++++++++++
 tb/tb_ram_stream_reader.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nessy_mem_pkg.sv
// rtl/nessy_mem_pkg.sv - shared FSM encoding and read-latency bounds for the RAM stream reader
//
// Purpose : state enum for ram_stream_reader plus the legal RAM read-latency
//           range and a helper that folds an out-of-range value into it.
// Ports   : none (package).
package nessy_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;

  // Keeps the delay line length legal even if an odd value is passed down.
  function automatic int clamp_rd_latency(input int lat);
    if (lat < RD_LATENCY_MIN) return RD_LATENCY_MIN;
    if (lat > RD_LATENCY_MAX) return RD_LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// rtl/ram_stream_reader_if.sv - RAM read port plus output stream bundle
//
// Purpose : groups the RAM read port and the valid/ready output stream.
// Signals : mem_rden, mem_address, mem_q   - RAM read port
//           out_data, out_valid, out_ready - output stream
// Modports: master = reader side, slave = RAM model / stream sink side.
interface ram_stream_reader_if #(
  parameter int WIDTH   = 8,
  parameter int WIDTHAD = 11
) ();

  logic               mem_rden;
  logic [WIDTHAD-1:0] mem_address;
  logic [WIDTH-1:0]   mem_q;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output mem_rden, mem_address, out_data, out_valid,
    input  mem_q, out_ready
  );

  modport slave (
    input  mem_rden, mem_address, out_data, out_valid,
    output mem_q, out_ready
  );

endinterface

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - small synchronous FIFO with flush, used as the stream output buffer
//
// Purpose : FIFO_DEPTH-entry buffer (power of two) with show-ahead read data.
// Ports   : clk_i, rst_ni (sync, active-low), flush_i (empties the FIFO),
//           wr_en_i/wr_data_i push, rd_en_i pop, rd_data_o head word
//           (0 while empty), valid_o not-empty, count_o occupancy.
module stream_fifo #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        wr_en_i,
  input  logic [WIDTH-1:0]            wr_data_i,
  input  logic                        rd_en_i,
  output logic [WIDTH-1:0]            rd_data_o,
  output logic                        valid_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign valid_o   = (count_o != '0);
  assign rd_data_o = valid_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - streams a block of RAM words out over a valid/ready interface
//
// Purpose : on start, reads length words from base_addr upward (address wraps)
//           and presents them in order on the output stream; done pulses the
//           cycle after the last word is accepted. abort cancels a transfer.
// Ports   : clock0, reset_n (sync, active-low); start/abort/base_addr/length
//           command; busy/done status; bus = RAM read port + output stream.
module ram_stream_reader
  import nessy_mem_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int WIDTHAD    = 11,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock0,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTHAD-1:0] base_addr,
  input  logic [WIDTHAD:0]   length,
  output logic               busy,
  output logic               done,
  ram_stream_reader_if.master bus
);

  localparam int LAT = clamp_rd_latency(RD_LATENCY);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 2;
  localparam logic [WIDTHAD-1:0] ADDR_ONE = WIDTHAD'(1);
  localparam logic [WIDTHAD:0]   CNT_ONE  = (WIDTHAD+1)'(1);

  rd_state_e          state_q, state_d;
  logic [WIDTHAD-1:0] addr_q, addr_d;
  logic [WIDTHAD:0]   rd_rem_q, rd_rem_d;
  logic [WIDTHAD:0]   out_rem_q, out_rem_d;
  logic [LAT-1:0]     vld_q, vld_d;
  logic               done_q, done_d;

  logic               rden;
  logic               flush;
  logic               pop;
  logic               fifo_valid;
  logic [AW:0]        fifo_count;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      level;

  // Each set bit in vld_q is a read still travelling through the RAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + CW'(vld_q[i]);
  end

  // Reads are only issued when every word already committed has a FIFO slot.
  assign level = inflight + CW'(fifo_count);
  assign pop   = fifo_valid & bus.out_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_rem_d  = rd_rem_q;
    out_rem_d = out_rem_q;
    done_d    = 1'b0;
    rden      = 1'b0;
    flush     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = ST_READ;
            addr_d    = base_addr;
            rd_rem_d  = length;
            out_rem_d = length;
          end
        end
      end
      ST_READ: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (level < CW'(FIFO_DEPTH)) begin
            rden     = 1'b1;
            addr_d   = addr_q + ADDR_ONE;
            rd_rem_d = rd_rem_q - CNT_ONE;
            if (rd_rem_q == CNT_ONE) state_d = ST_DRAIN;
          end
          if (pop) out_rem_d = out_rem_q - CNT_ONE;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (pop) begin
          out_rem_d = out_rem_q - CNT_ONE;
          if (out_rem_q == CNT_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    vld_d = flush ? '0 : LAT'({vld_q, rden});
  end

  always_ff @(posedge clock0) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rd_rem_q  <= '0;
      out_rem_q <= '0;
      vld_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_rem_q  <= rd_rem_d;
      out_rem_q <= out_rem_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
    end
  end

  stream_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clock0),
    .rst_ni    (reset_n),
    .flush_i   (flush),
    .wr_en_i   (vld_q[LAT-1]),
    .wr_data_i (bus.mem_q),
    .rd_en_i   (pop),
    .rd_data_o (bus.out_data),
    .valid_o   (fifo_valid),
    .count_o   (fifo_count)
  );

  assign bus.out_valid   = fifo_valid;
  assign bus.mem_rden    = rden;
  assign bus.mem_address = addr_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - scoreboard bench for ram_stream_reader at read latency 1 and 2
module tb_ram_stream_reader;

  localparam int W     = 8;
  localparam int AW    = 11;
  localparam int DEPTH = 4;

  logic          clock0 = 1'b0;
  logic          reset_n, start, abort, out_ready, rand_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          bz [2];
  logic          dn [2];
  logic          ov [2];
  logic          rd [2];
  logic [AW-1:0] ma [2];
  logic [W-1:0]  od [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int st_cyc;

  logic [W-1:0] ram [1<<AW];
  logic [W-1:0] q1a;
  logic [W-1:0] exp0 [$];
  logic [W-1:0] exp1 [$];

  logic done_due [2];
  int   outst [2], max_outst [2], hs_n [2], gaps [2], first_hs [2], last_hs [2], rd_cnt [2];
  logic hs_m;
  logic [W-1:0] e_m;
  int   sz_m;

  always #5 clock0 = ~clock0;
  always @(posedge clock0) cyc <= cyc + 1;

  ram_stream_reader_if #(.WIDTH(W), .WIDTHAD(AW)) bus0 ();
  ram_stream_reader_if #(.WIDTH(W), .WIDTHAD(AW)) bus1 ();

  ram_stream_reader #(.WIDTH(W), .WIDTHAD(AW), .RD_LATENCY(1), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .clock0(clock0), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .busy(bz[0]), .done(dn[0]), .bus(bus0)
  );

  ram_stream_reader #(.WIDTH(W), .WIDTHAD(AW), .RD_LATENCY(2), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .clock0(clock0), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .busy(bz[1]), .done(dn[1]), .bus(bus1)
  );

  assign bus0.out_ready = out_ready;
  assign bus1.out_ready = out_ready;
  assign ov[0] = bus0.out_valid;   assign ov[1] = bus1.out_valid;
  assign rd[0] = bus0.mem_rden;    assign rd[1] = bus1.mem_rden;
  assign ma[0] = bus0.mem_address; assign ma[1] = bus1.mem_address;
  assign od[0] = bus0.out_data;    assign od[1] = bus1.out_data;

  // RAM models: one-cycle and two-cycle read pipelines
  always @(posedge clock0) begin
    if (bus0.mem_rden) bus0.mem_q <= ram[bus0.mem_address];
    q1a        <= ram[bus1.mem_address];
    bus1.mem_q <= q1a;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_size(input int i);
    return (i == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic logic [W-1:0] exp_pop(input int i);
    if (i == 0) return exp0.pop_front();
    return exp1.pop_front();
  endfunction

  function automatic void exp_clear(input int i);
    if (i == 0) exp0.delete(); else exp1.delete();
  endfunction

  // Monitor: pops the scoreboard on every handshake and tracks done timing
  always @(negedge clock0) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        done_due[i] = 1'b0;
        outst[i]    = 0;
        exp_clear(i);
      end else begin
        check($sformatf("done_pulse[%0d] cyc %0d", i, cyc), dn[i], done_due[i]);
        done_due[i] = 1'b0;
        if (start && !abort) begin
          hs_n[i] = 0; gaps[i] = 0; max_outst[i] = 0;
        end
        if (rd[i]) begin
          rd_cnt[i]++;
          outst[i]++;
        end
        hs_m = ov[i] && out_ready;
        if (hs_m) begin
          outst[i]--;
          sz_m = exp_size(i);
          check($sformatf("word_expected[%0d]", i), sz_m > 0, 1);
          if (sz_m > 0) begin
            e_m = exp_pop(i);
            check($sformatf("out_data[%0d]", i), od[i], e_m);
            if (sz_m == 1 && !abort) done_due[i] = 1'b1;
          end
          hs_n[i]++;
          if (hs_n[i] == 1) first_hs[i] = cyc;
          else if (cyc != last_hs[i] + 1) gaps[i]++;
          last_hs[i] = cyc;
        end
        if (outst[i] > max_outst[i]) max_outst[i] = outst[i];
        if (rd[i]) check($sformatf("level_le_depth[%0d]", i), outst[i] <= DEPTH, 1);
        if (start && !abort && length == '0) done_due[i] = 1'b1;
        if (abort) begin
          outst[i] = 0;
          exp_clear(i);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock0);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_start(input int b, input int len);
    base_addr = AW'(b);
    length    = (AW+1)'(len);
    start     = 1'b1;
    st_cyc    = cyc;
    for (int k = 0; k < len; k++) begin
      exp0.push_back(ram[AW'(b + k)]);
      exp1.push_back(ram[AW'(b + k)]);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((bz[0] || bz[1] || exp0.size() != 0 || exp1.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("transfer_timeout", n < budget, 1);
    tick();
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s busy[%0d]", tag, i), bz[i], 0);
      check($sformatf("%s done[%0d]", tag, i), dn[i], 0);
      check($sformatf("%s mem_rden[%0d]", tag, i), rd[i], 0);
      check($sformatf("%s out_valid[%0d]", tag, i), ov[i], 0);
      check($sformatf("%s mem_address[%0d]", tag, i), ma[i], 0);
      check($sformatf("%s out_data[%0d]", tag, i), od[i], 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b, len, rc0, rc1;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; rand_ready = 1'b0;
    base_addr = '0; length = '0;
    for (int a = 0; a < (1 << AW); a++) ram[a] = W'(a);
    for (int i = 0; i < 2; i++) begin
      rd_cnt[i] = 0; hs_n[i] = 0; gaps[i] = 0; max_outst[i] = 0; first_hs[i] = 0; last_hs[i] = 0;
    end
    repeat (3) tick();
    check_reset_vals("reset");
    reset_n = 1'b1;
    tick();

    // basic block: consecutive words, first word latency, done after last
    do_start(11'h010, 4);
    wait_idle(200);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("first_latency_ok[%0d]", i), (first_hs[i] - st_cyc) <= (i + 3), 1);
      check($sformatf("word_count[%0d]", i), hs_n[i], 4);
      check($sformatf("gaps[%0d]", i), gaps[i], 0);
    end

    // address wrap
    do_start(11'h7FE, 4);
    wait_idle(200);
    for (int i = 0; i < 2; i++) check($sformatf("wrap_count[%0d]", i), hs_n[i], 4);

    // zero length: done next cycle, no reads
    rc0 = rd_cnt[0]; rc1 = rd_cnt[1];
    do_start(11'h055, 0);
    wait_idle(50);
    check("zero_len_reads[0]", rd_cnt[0] - rc0, 0);
    check("zero_len_reads[1]", rd_cnt[1] - rc1, 0);

    // backpressure mid-stream
    do_start(11'h100, 16);
    repeat (4) tick();
    out_ready = 1'b0;
    repeat (10) tick();
    out_ready = 1'b1;
    wait_idle(300);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("max_level[%0d]", i), max_outst[i], DEPTH);
      check($sformatf("bp_count[%0d]", i), hs_n[i], 16);
    end

    // start while busy is ignored
    do_start(11'h200, 6);
    tick();
    base_addr = 11'h300; length = 12'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(200);

    // abort on the third read
    do_start(11'h020, 8);
    tick();
    tick();
    abort = 1'b1;
    #1;
    check("abort_rden[0]", rd[0], 0);
    check("abort_rden[1]", rd[1], 0);
    tick();
    abort = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("abort_out_valid[%0d]", i), ov[i], 0);
      check($sformatf("abort_busy[%0d]", i), bz[i], 0);
    end
    repeat (3) tick();
    do_start(11'h040, 5);
    wait_idle(200);
    for (int i = 0; i < 2; i++) check($sformatf("post_abort_count[%0d]", i), hs_n[i], 5);

    // reset in the middle of a transfer
    do_start(11'h010, 4);
    tick();
    reset_n = 1'b0;
    tick();
    check_reset_vals("mid_reset");
    reset_n = 1'b1;
    repeat (3) tick();
    do_start(11'h010, 4);
    wait_idle(200);
    for (int i = 0; i < 2; i++) check($sformatf("post_reset_count[%0d]", i), hs_n[i], 4);

    // randomized transfers with random backpressure and occasional aborts
    for (int a = 0; a < (1 << AW); a++) ram[a] = W'($urandom);
    rand_ready = 1'b1;
    for (int t = 0; t < 30; t++) begin
      b   = $urandom_range(0, (1 << AW) - 1);
      len = $urandom_range(0, 20);
      do_start(b, len);
      if (len > 0 && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, len)) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      wait_idle(3000);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
